// File: rtl/mmio_pkg.sv
// mmio_pkg: shared constants for the mmio_tohost test peripheral.
//   - register offsets (addr[3:2]) inside the 16-byte window
//   - STATUS register bit positions
//   - controller state encoding
package mmio_pkg;

  localparam logic [1:0] OFF_CONSOLE = 2'd0;
  localparam logic [1:0] OFF_TOHOST  = 2'd1;
  localparam logic [1:0] OFF_CYCLE   = 2'd2;
  localparam logic [1:0] OFF_STATUS  = 2'd3;

  localparam int ST_HALTED   = 0;
  localparam int ST_EMPTY    = 1;
  localparam int ST_FULL     = 2;
  localparam int ST_OVERFLOW = 3;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/mmio_tohost_byte_fifo.sv
// byte_fifo: small synchronous byte FIFO for the console stream.
//   clk, reset (sync, active-low)
//   push, data : write request and byte; accepted when not full or when a
//                pop happens on the same edge
//   pop        : read request; ignored while empty
//   head       : current head byte, forced to 0 while empty
//   count      : occupancy, one bit wider than the pointers
//   full, empty: occupancy flags
module byte_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [7:0]               data,
  input  logic                     pop,
  output logic [7:0]               head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_do_pop;
  logic          w_do_push;

  assign empty     = (r_count == '0);
  assign full      = (r_count == CW'(DEPTH));
  assign w_do_pop  = pop & ~empty;
  assign w_do_push = push & (~full | w_do_pop);
  assign count     = r_count;
  // Stale storage is never exposed, so the head reads 0 after reset.
  assign head      = empty ? 8'h00 : r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= data;
  end

endmodule

// File: rtl/mmio_tohost.sv
// mmio_tohost: memory-mapped test peripheral (console, cycle counter, exit).
//   clk, reset (sync, active-low)
//   addr, wdata, we, re : CPU data-memory port
//   hit, rdata          : combinational window decode and read data
//   con_data, con_valid, con_ready : console byte stream (valid/ready)
//   halted, exit_code, done        : completion signalling
//
// state | meaning
// RUN   | normal operation, all registers writable
// DRAIN | TOHOST written, CPU writes ignored, FIFO still draining
// DONE  | halted and FIFO empty; terminal until reset
module mmio_tohost
  import mmio_pkg::*;
#(
  parameter logic [31:0] BASE       = 32'h0000_3F00,
  parameter int          FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        we,
  input  logic        re,
  output logic        hit,
  output logic [31:0] rdata,
  output logic [7:0]  con_data,
  output logic        con_valid,
  input  logic        con_ready,
  output logic        halted,
  output logic [31:0] exit_code,
  output logic        done
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [31:0]   r_cycle;
  logic [31:0]   r_exit_code;
  logic          r_overflow;

  logic [1:0]    w_off;
  logic          w_wr;
  logic          w_push_req;
  logic          w_push_ok;
  logic          w_pop;
  logic          w_tohost_wr;
  logic          w_status_wr;
  logic [CW-1:0] w_count;
  logic [CW-1:0] w_count_nxt;
  logic          w_empty_nxt;
  logic          w_full;
  logic          w_empty;
  logic          w_unused;

  assign w_unused    = ^addr[1:0];
  assign hit         = (addr[31:4] == BASE[31:4]);
  assign w_off       = addr[3:2];
  // Writes only take effect in RUN; DRAIN and DONE ignore every store.
  assign w_wr        = we & hit & (r_state == RUN);
  assign w_push_req  = w_wr & (w_off == OFF_CONSOLE);
  assign w_tohost_wr = w_wr & (w_off == OFF_TOHOST);
  assign w_status_wr = w_wr & (w_off == OFF_STATUS);
  assign w_pop       = con_ready & ~w_empty;
  assign w_push_ok   = w_push_req & (~w_full | w_pop);
  assign w_count_nxt = w_count + CW'(w_push_ok) - CW'(w_pop);
  // Looking at next-cycle occupancy lets done rise on the last pop edge.
  assign w_empty_nxt = (w_count_nxt == '0);

  byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (w_push_req),
    .data  (wdata[7:0]),
    .pop   (w_pop),
    .head  (con_data),
    .count (w_count),
    .full  (w_full),
    .empty (w_empty)
  );

  assign con_valid = ~w_empty;
  assign halted    = (r_state != RUN);
  assign done      = (r_state == DONE);
  assign exit_code = r_exit_code;

  always_ff @(posedge clk) begin
    if (!reset) r_state <= RUN;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      RUN:     if (w_tohost_wr) w_state_nxt = w_empty_nxt ? DONE : DRAIN;
      DRAIN:   if (w_empty_nxt) w_state_nxt = DONE;
      DONE:    w_state_nxt = DONE;
      default: w_state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_cycle     <= '0;
      r_exit_code <= '0;
      r_overflow  <= 1'b0;
    end else begin
      if (r_state == RUN) r_cycle <= r_cycle + 32'd1;
      if (w_tohost_wr)    r_exit_code <= wdata;
      if (w_push_req && !w_push_ok) r_overflow <= 1'b1;
      else if (w_status_wr)         r_overflow <= 1'b0;
    end
  end

  always_comb begin
    rdata = '0;
    if (hit && re) begin
      case (w_off)
        OFF_CONSOLE: rdata = 32'(w_count);
        OFF_TOHOST:  rdata = r_exit_code;
        OFF_CYCLE:   rdata = r_cycle;
        OFF_STATUS: begin
          rdata[ST_HALTED]   = halted;
          rdata[ST_EMPTY]    = w_empty;
          rdata[ST_FULL]     = w_full;
          rdata[ST_OVERFLOW] = r_overflow;
        end
        default:     rdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_tohost.sv
module tb_mmio_tohost;

  localparam logic [31:0] BASE  = 32'h0000_3F00;
  localparam logic [31:0] A_CON = BASE;
  localparam logic [31:0] A_TOH = BASE + 32'h4;
  localparam logic [31:0] A_CYC = BASE + 32'h8;
  localparam logic [31:0] A_ST  = BASE + 32'hC;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic        we = 1'b0;
  logic        re = 1'b0;
  logic        hit;
  logic [31:0] rdata;
  logic [7:0]  con_data;
  logic        con_valid;
  logic        con_ready = 1'b0;
  logic        halted;
  logic [31:0] exit_code;
  logic        done;

  int checks = 0;
  int errors = 0;

  logic [7:0]  con_q[$];
  logic [31:0] rd_q[$];

  int unsigned m_cyc = 0;
  bit          m_halt = 1'b0;
  int unsigned frozen;

  mmio_tohost #(.BASE(BASE), .FIFO_DEPTH(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .addr      (addr),
    .wdata     (wdata),
    .we        (we),
    .re        (re),
    .hit       (hit),
    .rdata     (rdata),
    .con_data  (con_data),
    .con_valid (con_valid),
    .con_ready (con_ready),
    .halted    (halted),
    .exit_code (exit_code),
    .done      (done)
  );

  always #5 clk = ~clk;

  // Reference cycle counter built from the bench's own stimulus.
  always @(posedge clk) begin
    if (!reset) begin
      m_cyc  = 0;
      m_halt = 1'b0;
    end else begin
      if (!m_halt) m_cyc = m_cyc + 1;
      if (we && addr[31:4] == BASE[31:4] && addr[3:2] == 2'd1) m_halt = 1'b1;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  // Monitor: console handshakes and read responses against the queues.
  always @(negedge clk) begin
    if (con_valid && con_ready) begin
      if (con_q.size() == 0) chk("con_unexpected", {24'b0, con_data}, 32'hFFFF_FFFF);
      else chk("con_data", {24'b0, con_data}, {24'b0, con_q.pop_front()});
    end
    if (re) begin
      if (rd_q.size() == 0) chk("rd_unexpected", rdata, 32'hFFFF_FFFF);
      else chk("rdata", rdata, rd_q.pop_front());
    end
  end

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    addr = a; wdata = d; we = 1'b1;
    @(posedge clk); #1;
    we = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] exp);
    addr = a; re = 1'b1;
    rd_q.push_back(exp);
    @(posedge clk); #1;
    re = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  initial begin
    // Reset values
    repeat (2) @(posedge clk);
    #1;
    chk("rst_con_valid", {31'b0, con_valid}, 32'd0);
    chk("rst_con_data", {24'b0, con_data}, 32'd0);
    chk("rst_halted", {31'b0, halted}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_exit_code", exit_code, 32'd0);
    addr = A_CON; #1;
    chk("rst_hit", {31'b0, hit}, 32'd1);
    chk("rdata_no_re", rdata, 32'd0);
    reset = 1'b1;

    // CYCLE after 10 edges with reset high, then one more
    repeat (10) @(posedge clk);
    #1;
    rd(A_CYC, 32'd10);
    rd(A_CYC, 32'd11);

    // Console order with con_ready high
    con_ready = 1'b1;
    con_q.push_back(8'h48);
    con_q.push_back(8'h69);
    addr = A_CON; wdata = 32'h48; we = 1'b1;
    @(posedge clk); #1;
    wdata = 32'h69;
    @(negedge clk);
    chk("order_first", {23'b0, con_valid, con_data}, {23'b0, 1'b1, 8'h48});
    @(posedge clk); #1;
    we = 1'b0;
    @(negedge clk);
    chk("order_second", {23'b0, con_valid, con_data}, {23'b0, 1'b1, 8'h69});
    tick();
    chk("order_empty", {31'b0, con_valid}, 32'd0);

    // Overflow: 9 pushes into depth 8 with the sink stalled
    con_ready = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      if (i <= 8) con_q.push_back(8'(i));
      wr(A_CON, 32'(i));
    end
    rd(A_CON, 32'd8);
    rd(A_ST, 32'hC);          // overflow | full
    wr(A_ST, 32'd0);
    rd(A_ST, 32'h4);          // full only

    // Full plus pop: push 0xAA on the edge that pops byte 1
    con_ready = 1'b1;
    con_q.push_back(8'hAA);
    wr(A_CON, 32'hAA);
    con_ready = 1'b0;
    rd(A_CON, 32'd8);
    rd(A_ST, 32'h4);

    // Drain everything
    con_ready = 1'b1;
    for (int i = 0; i < 40 && con_valid; i++) tick();
    chk("drain_empty", {31'b0, con_valid}, 32'd0);
    chk("drain_queue", 32'(con_q.size()), 32'd0);
    con_ready = 1'b0;

    // Decode: one window above BASE is not us
    addr = BASE + 32'h10; #1;
    chk("decode_miss_hit", {31'b0, hit}, 32'd0);
    wr(BASE + 32'h10, 32'h55);
    wr(BASE + 32'h14, 32'h99);
    chk("decode_miss_valid", {31'b0, con_valid}, 32'd0);
    chk("decode_miss_halt", {31'b0, halted}, 32'd0);
    rd(BASE + 32'h18, 32'd0);
    rd(A_CON, 32'd0);

    // Halt and drain
    con_q.push_back(8'h11); wr(A_CON, 32'h11);
    con_q.push_back(8'h22); wr(A_CON, 32'h22);
    con_q.push_back(8'h33); wr(A_CON, 32'h33);
    wr(A_TOH, 32'h2A);
    frozen = m_cyc;
    chk("halt_halted", {31'b0, halted}, 32'd1);
    chk("halt_exit", exit_code, 32'h2A);
    chk("halt_done", {31'b0, done}, 32'd0);
    wr(A_CON, 32'h77);
    wr(A_TOH, 32'h55);
    rd(A_CON, 32'd3);
    rd(BASE + 32'h7, 32'h2A);
    rd(A_CYC, frozen);
    rd(A_CYC, frozen);
    con_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("drain_done_low", {31'b0, done}, 32'd0);
    end
    @(negedge clk);
    chk("drain_done_high", {31'b0, done}, 32'd1);
    chk("drain_valid_low", {31'b0, con_valid}, 32'd0);
    tick();
    rd(A_ST, 32'h3);          // empty | halted

    // Reset mid-operation
    reset = 1'b0;
    tick();
    reset = 1'b1;
    chk("rst2_halted", {31'b0, halted}, 32'd0);
    chk("rst2_done", {31'b0, done}, 32'd0);
    chk("rst2_exit", exit_code, 32'd0);
    rd(A_CYC, 32'd0);

    // Reset discards queued console bytes
    con_ready = 1'b0;
    wr(A_CON, 32'h5A);
    rd(A_CON, 32'd1);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    con_q.delete();
    chk("rst3_valid", {31'b0, con_valid}, 32'd0);
    chk("rst3_data", {24'b0, con_data}, 32'd0);

    // TOHOST with empty FIFO goes straight to done
    wr(A_TOH, 32'h0000_0007);
    chk("direct_done", {31'b0, done}, 32'd1);
    chk("direct_exit", exit_code, 32'd7);
    rd(A_ST, 32'h3);

    tick();
    chk("final_con_q", 32'(con_q.size()), 32'd0);
    chk("final_rd_q", 32'(rd_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
